image_rom_arbiter: RTL and testbench
====================================

IMAGE_ROM_ARBITER -- requirements
Module: image_rom_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH_BITS, 8, column address width.
- HEIGHT_BITS, 8, row address width.
- RD_LATENCY, 1, image ROM read latency in cycles.
- LOCK_MAX, 16, maximum consecutive locked grants.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- iReq0 / iReq1  in  1  read request (0 = box filter, 1 = threshold).
- iLock0 / iLock1  in  1  keep grant on next cycle (burst).
- iCol0 / iCol1  in  WIDTH_BITS  requested column.
- iRow0 / iRow1  in  HEIGHT_BITS  requested row.
- oGnt0 / oGnt1  out  1  request accepted this cycle.
- oValid0 / oValid1  out  1  oRdData belongs to this requester this cycle.
- oRdData  out  8  read data.
- oCol  out  WIDTH_BITS  ROM column address.
- oRow  out  HEIGHT_BITS  ROM row address.
- iRomData  in  8  ROM read data.
- oGntCount0 / oGntCount1  out  16  grants issued per requester.

Function
REQ-004 At most one of oGnt0/oGnt1 SHALL be high in any cycle; a grant is combinational from the current requests and registered state.
REQ-005 A requester whose iReq is high SHALL get oGnt in that cycle if the other requester is not requesting.
REQ-006 When both request, no lock applies: grant the requester NOT granted most recently; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-007 Lock rule: if requester N was granted in cycle t-1 with iLockN high, and iReqN is high in cycle t, then N is granted in cycle t regardless of the other request.
REQ-008 A lock run SHALL be capped at LOCK_MAX consecutive grants. If the other requester is waiting when the cap is reached, the lock is ignored for one arbitration and the other requester is granted. The run counter clears on any non-locked grant or idle cycle.
REQ-009 Locks SHALL not apply in these cases:
- iLock high without iReq.
- iLock high in a cycle without a grant.
REQ-010 oCol/oRow SHALL equal the granted requester's iCol/iRow. With no grant, they SHALL equal iCol0/iRow0.
REQ-011 A grant in cycle t SHALL produce oValidN high in exactly cycle t+RD_LATENCY, tracked by a RD_LATENCY-deep {valid, id} tag pipeline; it accepts one grant per cycle, giving full throughput.
REQ-012 oRdData SHALL equal iRomData every cycle, with no extra register.
REQ-013 A non-granted requester SHALL hold iReq, iCol and iRow stable until granted; the arbiter does not buffer requests.
REQ-014 oGntCountN SHALL increment on each oGntN and saturate at 16'hFFFF.
REQ-015 Requests that fall away before a grant SHALL not affect the pointer or the counters.

Reset
REQ-016 With reset high at a rising edge, these SHALL be reset:
- last-grant pointer = 1.
- lock run counter = 0.
- all tag stages invalid.
- oGntCount0/1 = 0.
REQ-017 While reset is high, oGnt0/1 and oValid0/1 SHALL be forced 0.
REQ-018 Reads in flight when reset asserts SHALL be discarded; no oValid pulse may appear for them after reset releases.
REQ-019 The first grant SHALL be possible in the first cycle with reset low.

Structure
REQ-020 A shared package image_mem_pkg SHALL hold WIDTH_BITS, HEIGHT_BITS, RD_LATENCY, LOCK_MAX and the requester-id encoding (REQ_BOX=0, REQ_THR=1).
REQ-021 The tag pipeline SHALL be a sub-module rd_tag_pipe, parameterised by depth, with input {valid, id} and output {valid, id}; all other logic is flat in image_rom_arbiter.

Verification
REQ-022 Single requester: iReq0=1, col=3, row=5, for one cycle -> oGnt0=1 and oCol=3/oRow=5 the same cycle; oValid0=1 with oRdData=ROM[5][3] one cycle later; oGntCount0=1.
REQ-023 Tie at reset: both request from the first cycle, no lock -> grants alternate 0,1,0,1; each oValidN follows its grant by exactly 1 cycle.
REQ-024 Lock cap: iReq0=iLock0=1 continuously, iReq1=1 from cycle 2 -> 16 consecutive oGnt0, then one oGnt1, then requester 0 resumes.
REQ-025 Lock without request: iLock1=1 with iReq1=0 while iReq0=1 -> oGnt0 every cycle.
REQ-026 Reset mid-burst: grant 0 in cycle t, reset in cycle t -> no oValid0 in cycle t+1; counters read 0; next tie grants requester 0.
REQ-027 Saturation: force 65540 grants to requester 1 -> oGntCount1 holds 16'hFFFF.

Source files
------------

// File: rtl/image_mem_pkg.sv
// Shared geometry, timing and requester-id constants for the image ROM
// arbiter and its read-tag pipeline.
package image_mem_pkg;

  localparam int WIDTH_BITS  = 8;
  localparam int HEIGHT_BITS = 8;
  localparam int RD_LATENCY  = 1;
  localparam int LOCK_MAX    = 16;

  localparam int NUM_REQ = 2;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef logic reqId_t;
  localparam reqId_t REQ_BOX = 1'b0;
  localparam reqId_t REQ_THR = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line carrying {valid, requester id} alongside an outstanding ROM read
// so the returning data can be steered to the requester that issued it.
module rd_tag_pipe
  import image_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   iValid,
  input  reqId_t iId,
  output logic   oValid,
  output reqId_t oId
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gStage
    logic   validReg;
    reqId_t idReg;
    logic   validIn;
    reqId_t idIn;

    if (gi == 0) begin : gHead
      assign validIn = iValid;
      assign idIn    = iId;
    end else begin : gBody
      assign validIn = gStage[gi-1].validReg;
      assign idIn    = gStage[gi-1].idReg;
    end

    // Only the valid bits need clearing; a stale id is harmless without valid.
    always_ff @(posedge clock) begin
      if (reset) begin
        validReg <= 1'b0;
      end else begin
        validReg <= validIn;
      end
      idReg <= idIn;
    end
  end

  assign oValid = gStage[DEPTH-1].validReg;
  assign oId    = gStage[DEPTH-1].idReg;

endmodule

// File: rtl/image_rom_arbiter.sv
// Two-requester arbiter in front of the image ROM: round-robin on ties,
// optional burst locking with a run cap, read-data steering and grant counters.
module image_rom_arbiter
  import image_mem_pkg::*;
#(
  parameter int WIDTH_BITS  = image_mem_pkg::WIDTH_BITS,
  parameter int HEIGHT_BITS = image_mem_pkg::HEIGHT_BITS,
  parameter int RD_LATENCY  = image_mem_pkg::RD_LATENCY,
  parameter int LOCK_MAX    = image_mem_pkg::LOCK_MAX
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iReq0,
  input  logic                   iReq1,
  input  logic                   iLock0,
  input  logic                   iLock1,
  input  logic [WIDTH_BITS-1:0]  iCol0,
  input  logic [WIDTH_BITS-1:0]  iCol1,
  input  logic [HEIGHT_BITS-1:0] iRow0,
  input  logic [HEIGHT_BITS-1:0] iRow1,
  output logic                   oGnt0,
  output logic                   oGnt1,
  output logic                   oValid0,
  output logic                   oValid1,
  output logic [7:0]             oRdData,
  output logic [WIDTH_BITS-1:0]  oCol,
  output logic [HEIGHT_BITS-1:0] oRow,
  input  logic [7:0]             iRomData,
  output logic [15:0]            oGntCount0,
  output logic [15:0]            oGntCount1
);

  localparam int RUN_BITS = $clog2(LOCK_MAX + 1);
  localparam logic [RUN_BITS-1:0] RUN_CAP = RUN_BITS'(LOCK_MAX - 1);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;
  logic [NUM_REQ-1:0] gnt;

  reqId_t              lastGntReg, lastGntNext;
  logic                lockValidReg, lockValidNext;
  reqId_t              lockOwnerReg, lockOwnerNext;
  logic [RUN_BITS-1:0] runCountReg, runCountNext;

  logic   lockHit;
  logic   capHit;
  logic   gntValid;
  reqId_t gntId;
  logic   lockedGnt;

  logic   tagValid;
  reqId_t tagId;

  assign req  = {iReq1, iReq0};
  assign lock = {iLock1, iLock0};

  // The run counter counts locked grants after the opening grant, so the cap
  // trips when the owner already holds LOCK_MAX consecutive grants.
  assign lockHit = lockValidReg && req[lockOwnerReg];
  assign capHit  = lockHit && (runCountReg >= RUN_CAP) && req[~lockOwnerReg];

  always_comb begin
    gntValid  = 1'b0;
    gntId     = REQ_BOX;
    lockedGnt = 1'b0;
    if (!reset) begin
      if (lockHit && !capHit) begin
        gntValid  = 1'b1;
        gntId     = lockOwnerReg;
        lockedGnt = 1'b1;
      end else if (req[0] && req[1]) begin
        gntValid = 1'b1;
        gntId    = ~lastGntReg;
      end else if (req != '0) begin
        gntValid = 1'b1;
        gntId    = req[1] ? REQ_THR : REQ_BOX;
      end
    end
  end

  always_comb begin
    lastGntNext   = lastGntReg;
    lockValidNext = 1'b0;
    lockOwnerNext = lockOwnerReg;
    runCountNext  = '0;
    if (gntValid) begin
      lastGntNext   = gntId;
      lockValidNext = lock[gntId];
      lockOwnerNext = gntId;
      if (lockedGnt) begin
        runCountNext = (runCountReg >= RUN_CAP) ? RUN_CAP : runCountReg + RUN_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lastGntReg   <= REQ_THR;
      lockValidReg <= 1'b0;
      lockOwnerReg <= REQ_BOX;
      runCountReg  <= '0;
    end else begin
      lastGntReg   <= lastGntNext;
      lockValidReg <= lockValidNext;
      lockOwnerReg <= lockOwnerNext;
      runCountReg  <= runCountNext;
    end
  end

  assign oGnt0 = gntValid && (gntId == REQ_BOX);
  assign oGnt1 = gntValid && (gntId == REQ_THR);
  assign gnt   = {oGnt1, oGnt0};

  assign oCol = oGnt1 ? iCol1 : iCol0;
  assign oRow = oGnt1 ? iRow1 : iRow0;

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) uTagPipe (
    .clock  (clock),
    .reset  (reset),
    .iValid (gntValid),
    .iId    (gntId),
    .oValid (tagValid),
    .oId    (tagId)
  );

  assign oValid0 = !reset && tagValid && (tagId == REQ_BOX);
  assign oValid1 = !reset && tagValid && (tagId == REQ_THR);
  assign oRdData = iRomData;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gCount
    logic [15:0] countReg;

    always_ff @(posedge clock) begin
      if (reset) begin
        countReg <= '0;
      end else if (gnt[gi] && (countReg != COUNT_MAX)) begin
        countReg <= countReg + 16'd1;
      end
    end
  end

  assign oGntCount0 = gCount[0].countReg;
  assign oGntCount1 = gCount[1].countReg;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter with a one-cycle registered ROM model
// whose byte at (row, col) is {row[3:0], col[3:0]}.
module tb_image_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iReq0 = 1'b0, iReq1 = 1'b0;
  logic        iLock0 = 1'b0, iLock1 = 1'b0;
  logic [7:0]  iCol0 = '0, iCol1 = '0, iRow0 = '0, iRow1 = '0;
  logic        oGnt0, oGnt1, oValid0, oValid1;
  logic [7:0]  oRdData, oCol, oRow;
  logic [7:0]  iRomData = '0;
  logic [15:0] oGntCount0, oGntCount1;

  int testsRun = 0;
  int testsFailed = 0;

  image_rom_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .iReq0      (iReq0),
    .iReq1      (iReq1),
    .iLock0     (iLock0),
    .iLock1     (iLock1),
    .iCol0      (iCol0),
    .iCol1      (iCol1),
    .iRow0      (iRow0),
    .iRow1      (iRow1),
    .oGnt0      (oGnt0),
    .oGnt1      (oGnt1),
    .oValid0    (oValid0),
    .oValid1    (oValid1),
    .oRdData    (oRdData),
    .oCol       (oCol),
    .oRow       (oRow),
    .iRomData   (iRomData),
    .oGntCount0 (oGntCount0),
    .oGntCount1 (oGntCount1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) iRomData <= {oRow[3:0], oCol[3:0]};

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clearInputs();
    iReq0 = 1'b0; iReq1 = 1'b0; iLock0 = 1'b0; iLock1 = 1'b0;
    iCol0 = '0; iCol1 = '0; iRow0 = '0; iRow1 = '0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    clearInputs();
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  initial begin
    // Grants and valids forced low under reset, even with both requesting
    iReq0 = 1'b1; iReq1 = 1'b1;
    #2;
    checkValue("reset.gnt0", oGnt0, 1'b0);
    checkValue("reset.gnt1", oGnt1, 1'b0);
    nextCycle(); settle();
    checkValue("reset.valid0", oValid0, 1'b0);
    checkValue("reset.valid1", oValid1, 1'b0);
    checkValue("reset.count0", oGntCount0, 16'd0);
    checkValue("reset.count1", oGntCount1, 16'd0);
    resetDut();

    // Single requester, first cycle out of reset
    iReq0 = 1'b1; iCol0 = 8'd3; iRow0 = 8'd5; iCol1 = 8'd9; iRow1 = 8'd9;
    settle();
    checkValue("single.gnt0", oGnt0, 1'b1);
    checkValue("single.gnt1", oGnt1, 1'b0);
    checkValue("single.col", oCol, 8'd3);
    checkValue("single.row", oRow, 8'd5);
    nextCycle();
    iReq0 = 1'b0;
    settle();
    checkValue("single.gnt0_after", oGnt0, 1'b0);
    checkValue("single.valid0", oValid0, 1'b1);
    checkValue("single.valid1", oValid1, 1'b0);
    checkValue("single.data", oRdData, 8'h53);
    checkValue("single.count0", oGntCount0, 16'd1);

    // Tie from reset alternates 0,1,0,1 with data one cycle behind
    resetDut();
    iReq0 = 1'b1; iReq1 = 1'b1;
    iCol0 = 8'd1; iRow0 = 8'd1; iCol1 = 8'd2; iRow1 = 8'd2;
    for (int k = 0; k < 5; k++) begin
      settle();
      checkValue($sformatf("tie.gnt0[%0d]", k), oGnt0, (k % 2) == 0);
      checkValue($sformatf("tie.gnt1[%0d]", k), oGnt1, (k % 2) == 1);
      checkValue($sformatf("tie.col[%0d]", k), oCol, ((k % 2) == 1) ? 8'd2 : 8'd1);
      if (k > 0) begin
        checkValue($sformatf("tie.valid0[%0d]", k), oValid0, ((k - 1) % 2) == 0);
        checkValue($sformatf("tie.valid1[%0d]", k), oValid1, ((k - 1) % 2) == 1);
        checkValue($sformatf("tie.data[%0d]", k), oRdData, (((k - 1) % 2) == 0) ? 8'h11 : 8'h22);
      end
      nextCycle();
    end

    // Lock cap: 16 grants to 0, one to 1, then 0 resumes
    resetDut();
    iReq0 = 1'b1; iLock0 = 1'b1;
    iCol0 = 8'd4; iRow0 = 8'd6; iCol1 = 8'd7; iRow1 = 8'd8;
    for (int c = 0; c < 20; c++) begin
      iReq1 = (c >= 2);
      settle();
      checkValue($sformatf("cap.gnt0[%0d]", c), oGnt0, c != 16);
      checkValue($sformatf("cap.gnt1[%0d]", c), oGnt1, c == 16);
      checkValue($sformatf("cap.valid1[%0d]", c), oValid1, c == 17);
      nextCycle();
    end
    clearInputs();
    settle();
    checkValue("cap.count0", oGntCount0, 16'd19);
    checkValue("cap.count1", oGntCount1, 16'd1);

    // Lock without request is ignored; later lock on a real grant holds
    resetDut();
    iReq0 = 1'b1; iLock1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      iReq1 = (c >= 3);
      settle();
      checkValue($sformatf("nolock.gnt0[%0d]", c), oGnt0, c < 3);
      checkValue($sformatf("nolock.gnt1[%0d]", c), oGnt1, c >= 3);
      nextCycle();
    end

    // Reset mid-burst discards the read in flight and restores the pointer
    resetDut();
    iReq0 = 1'b1; iCol0 = 8'd3; iRow0 = 8'd5;
    settle();
    checkValue("rstmid.gnt0_pre", oGnt0, 1'b1);
    nextCycle();
    reset = 1'b1;
    settle();
    checkValue("rstmid.gnt0_forced", oGnt0, 1'b0);
    checkValue("rstmid.valid0_forced", oValid0, 1'b0);
    nextCycle();
    reset = 1'b0; iReq0 = 1'b0;
    settle();
    checkValue("rstmid.valid0_after", oValid0, 1'b0);
    checkValue("rstmid.count0", oGntCount0, 16'd0);
    checkValue("rstmid.count1", oGntCount1, 16'd0);
    iReq0 = 1'b1; iReq1 = 1'b1;
    #1;
    checkValue("rstmid.tie_gnt0", oGnt0, 1'b1);
    nextCycle();

    // Saturation of the grant counter
    resetDut();
    iReq1 = 1'b1;
    repeat (65534) nextCycle();
    settle();
    checkValue("sat.count1_near", oGntCount1, 16'hFFFE);
    nextCycle();
    repeat (5) nextCycle();
    settle();
    checkValue("sat.count1", oGntCount1, 16'hFFFF);
    checkValue("sat.count0", oGntCount0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
